// File: rtl/router_fifo_pkt.sv
// Packet-aware router output FIFO: stores {header tag, byte} words, tracks packet
// boundaries on both sides and flags sop/eop, stored-packet count and sticky errors.
module router_fifo_pkt #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = 14,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  soft_reset,
    input  logic                  w_en,
    input  logic                  r_en,
    input  logic                  lfd_state,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    output logic                  dout_valid,
    output logic                  sop,
    output logic                  eop,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [CNT_WIDTH-1:0]  pkt_cnt,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int RW = DATA_WIDTH - 1;
    localparam int EW = DATA_WIDTH + 1;
    localparam logic [RW-1:0]        REM_ONE = RW'(1);
    localparam logic [AW:0]          PTR_ONE = (AW + 1)'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [AW:0]          AF_THR  = (AW + 1)'(AF_LEVEL);

    // Remaining words after a header: payload length plus the parity byte.
    function automatic logic [RW-1:0] pkt_rem(input logic [DATA_WIDTH-1:0] hdr);
        return {1'b0, hdr[DATA_WIDTH-1:2]} + REM_ONE;
    endfunction

    logic [EW-1:0]          mem_r [DEPTH];
    logic [AW:0]            wr_ptr_r, rd_ptr_r, occ_r;
    logic [AW:0]            wr_ptr_nxt_s, rd_ptr_nxt_s, occ_nxt_s;
    logic [RW-1:0]          wr_rem_r, rd_rem_r, wr_rem_nxt_s, rd_rem_nxt_s;
    logic [CNT_WIDTH-1:0]   pkt_cnt_r, pkt_cnt_nxt_s;
    logic [DATA_WIDTH-1:0]  d_out_r;
    logic                   dout_valid_r, sop_r, eop_r, empty_r, full_r, af_r;
    logic                   overflow_r, underflow_r;
    logic                   wr_ok_s, rd_ok_s, clear_s;
    logic                   pkt_inc_s, pkt_dec_s, eop_nxt_s;
    logic                   full_nxt_s, empty_nxt_s;
    logic [EW-1:0]          pop_word_s;

    assign clear_s    = reset || soft_reset;
    assign rd_ok_s    = r_en && !empty_r;
    assign wr_ok_s    = w_en && (!full_r || rd_ok_s);
    assign pop_word_s = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer, occupancy and full/empty next-state decode.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        occ_nxt_s    = occ_r;
        if (wr_ok_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (rd_ok_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        case ({wr_ok_s, rd_ok_s})
            2'b10:   occ_nxt_s = occ_r + PTR_ONE;
            2'b01:   occ_nxt_s = occ_r - PTR_ONE;
            default: occ_nxt_s = occ_r;
        endcase
        empty_nxt_s = (wr_ptr_nxt_s == rd_ptr_nxt_s);
        full_nxt_s  = (wr_ptr_nxt_s[AW] != rd_ptr_nxt_s[AW]) &&
                      (wr_ptr_nxt_s[AW-1:0] == rd_ptr_nxt_s[AW-1:0]);
    end

    // Write-side packet tracking: a header reload abandons any unfinished packet.
    always_comb begin
        wr_rem_nxt_s = wr_rem_r;
        pkt_inc_s    = 1'b0;
        if (wr_ok_s && lfd_state) begin
            wr_rem_nxt_s = pkt_rem(d_in);
        end else if (wr_ok_s && (wr_rem_r != '0)) begin
            wr_rem_nxt_s = wr_rem_r - REM_ONE;
            pkt_inc_s    = (wr_rem_r == REM_ONE);
        end else begin
            wr_rem_nxt_s = wr_rem_r;
        end
    end

    // Read-side packet tracking mirrors the write side on popped tags.
    always_comb begin
        rd_rem_nxt_s = rd_rem_r;
        pkt_dec_s    = 1'b0;
        eop_nxt_s    = 1'b0;
        if (rd_ok_s && pop_word_s[EW-1]) begin
            rd_rem_nxt_s = pkt_rem(pop_word_s[DATA_WIDTH-1:0]);
        end else if (rd_ok_s && (rd_rem_r != '0)) begin
            rd_rem_nxt_s = rd_rem_r - REM_ONE;
            pkt_dec_s    = (rd_rem_r == REM_ONE);
            eop_nxt_s    = (rd_rem_r == REM_ONE);
        end else begin
            rd_rem_nxt_s = rd_rem_r;
        end
        case ({pkt_inc_s, pkt_dec_s})
            2'b10:   pkt_cnt_nxt_s = pkt_cnt_r + CNT_ONE;
            2'b01:   pkt_cnt_nxt_s = pkt_cnt_r - CNT_ONE;
            default: pkt_cnt_nxt_s = pkt_cnt_r;
        endcase
    end

    // Storage array; stale contents are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (wr_ok_s && !clear_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {lfd_state, d_in};
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (clear_s) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            occ_r        <= '0;
            wr_rem_r     <= '0;
            rd_rem_r     <= '0;
            pkt_cnt_r    <= '0;
            d_out_r      <= '0;
            dout_valid_r <= 1'b0;
            sop_r        <= 1'b0;
            eop_r        <= 1'b0;
            empty_r      <= 1'b1;
            full_r       <= 1'b0;
            af_r         <= 1'b0;
            overflow_r   <= 1'b0;
            underflow_r  <= 1'b0;
        end else begin
            wr_ptr_r     <= wr_ptr_nxt_s;
            rd_ptr_r     <= rd_ptr_nxt_s;
            occ_r        <= occ_nxt_s;
            wr_rem_r     <= wr_rem_nxt_s;
            rd_rem_r     <= rd_rem_nxt_s;
            pkt_cnt_r    <= pkt_cnt_nxt_s;
            dout_valid_r <= rd_ok_s;
            sop_r        <= rd_ok_s && pop_word_s[EW-1];
            eop_r        <= eop_nxt_s;
            empty_r      <= empty_nxt_s;
            full_r       <= full_nxt_s;
            af_r         <= (occ_nxt_s >= AF_THR);
            overflow_r   <= overflow_r || (w_en && full_r && !rd_ok_s);
            underflow_r  <= underflow_r || (r_en && empty_r);
            if (rd_ok_s) begin
                d_out_r <= pop_word_s[DATA_WIDTH-1:0];
            end else begin
                d_out_r <= d_out_r;
            end
        end
    end

    assign d_out       = d_out_r;
    assign dout_valid  = dout_valid_r;
    assign sop         = sop_r;
    assign eop         = eop_r;
    assign empty       = empty_r;
    assign full        = full_r;
    assign almost_full = af_r;
    assign pkt_cnt     = pkt_cnt_r;
    assign overflow    = overflow_r;
    assign underflow   = underflow_r;

endmodule

// File: doc/router_fifo_pkt.md
Name: router_fifo_pkt

Overview:
- Parametrised, packet-aware successor to the router 1x3 output FIFO.
- Buffers header/payload/parity bytes, tagging each word with the write-side lfd_state bit.
- Tracks packet boundaries on both write and read sides and reports start/end of packet on the read side, plus a stored-packet count, almost-full and sticky error flags.
- One instance sits in front of each of the three router output channels.

Parameters:
- DATA_WIDTH, 8: data byte width; header payload length field is d_in[DATA_WIDTH-1:2].
- DEPTH, 16: number of entries; power of two, at least 4.
- AF_LEVEL, 14: almost_full asserts when occupancy >= AF_LEVEL.
- CNT_WIDTH, 5: width of pkt_cnt; must hold DEPTH/2.

Ports:
- clk  in  1  single system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- soft_reset  in  1  synchronous, active-high channel flush (read-timeout flush).
- w_en  in  1  write request.
- r_en  in  1  read request.
- lfd_state  in  1  high with w_en when d_in is a header byte.
- d_in  in  DATA_WIDTH  write data.
- d_out  out  DATA_WIDTH  registered read data.
- dout_valid  out  1  d_out holds a word popped last cycle.
- sop  out  1  qualifies d_out as a header word (stored tag).
- eop  out  1  qualifies d_out as the parity (last) word.
- empty  out  1  occupancy == 0.
- full  out  1  occupancy == DEPTH.
- almost_full  out  1  occupancy >= AF_LEVEL.
- pkt_cnt  out  CNT_WIDTH  complete packets currently stored.
- overflow  out  1  sticky: write attempted while full and not simultaneously read.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Reset values:
  - d_out = 0; dout_valid, sop, eop, full, almost_full, overflow, underflow = 0.
  - empty = 1; pkt_cnt = 0; pointers, occupancy and packet counters = 0.
- Priority: reset > soft_reset > normal operation. soft_reset has the same effect as reset, including clearing the sticky flags; it takes effect mid-packet and drops all stored words.
- Storage:
  - Each entry is DATA_WIDTH+1 bits: {lfd_state, d_in}.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally.
  - full/empty are decoded from the pointers (MSB differs and LSBs equal = full).
- Write accepted when w_en and (!full or read accepted in the same cycle).
- Read accepted when r_en and !empty.
- Full with w_en and r_en both high: both are accepted and occupancy is unchanged.
- Empty with w_en and r_en both high: write accepted; read not accepted; underflow set.
- Rejected write (full, no read accepted): data dropped, overflow set, pointers unchanged.
- Read latency: 1 cycle.
  - The cycle after an accepted read: d_out = stored data, sop = stored tag, dout_valid = 1, eop per the read-side counter.
  - When no read is accepted: dout_valid = 0, sop = 0, eop = 0, and d_out holds its last value.
- Write-side packet counter wr_rem:
  - An accepted write with lfd_state = 1 loads wr_rem = len + 1 (payload plus parity).
  - Each subsequent accepted non-header write decrements wr_rem.
  - The write that takes wr_rem from 1 to 0 marks the packet complete and increments pkt_cnt.
- Read-side counter rd_rem:
  - A popped word with tag = 1 loads rd_rem = len + 1.
  - Each subsequent popped word decrements rd_rem.
  - The pop that takes rd_rem from 1 to 0 drives eop = 1 in the following cycle and decrements pkt_cnt.
- pkt_cnt increment and decrement in the same cycle leave it unchanged.
- Header with len = 0: the parity write completes the packet immediately; the parity pop gives eop.
- Header written while wr_rem != 0: the counter reloads and the abandoned packet is not counted. The read side behaves the same on reading a tagged word.
- Occupancy counter is log2(DEPTH)+1 bits; almost_full and the flags are registered from the next-state occupancy, so they are valid in the same cycle as the pointers.

Test Plan:
- Basic packet, DEPTH=16: reset, write header 8'h39 (len 14, addr 01) with lfd_state=1, then 14 payload bytes and parity.
  - Writing: almost_full rises after the 14th write; after the 16th write full=1 and pkt_cnt=1.
  - Reading 16 words: sop=1 on the first output, eop=1 on the 16th; then empty=1 and pkt_cnt=0.
- Overflow: fill 16 words, then assert w_en alone with d_in=8'hAA -> overflow=1, occupancy stays 16, and 8'hAA is never read out.
- Full plus simultaneous read/write: with the FIFO full, pulse w_en and r_en together for 3 cycles -> full stays 1, no overflow, output order preserved.
- Underflow: on an empty FIFO assert r_en -> underflow=1, dout_valid=0, d_out unchanged. Apply reset -> underflow=0.
- Soft reset mid-packet:
  - Write header 8'h15 (len 5) plus 3 payload bytes, then assert soft_reset for 1 cycle -> empty=1, pkt_cnt=0, dout_valid=0.
  - A following full packet is written and read normally.
- Back-to-back packets: write len-2 and len-3 packets (9 words), then read continuously -> sop on words 1 and 5, eop on words 4 and 9; pkt_cnt goes 2→1→0.
